dec_n_seq: RTL and testbench



---
 rtl/dec_pkg.sv | 13 +
 rtl/dec_onehot.sv | 19 +
 rtl/dec_n_seq.sv | 136 +++++++++++++
 tb/tb_dec_n_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared state and mode encodings for the dec_n_seq one-hot decoder.
package dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder, optionally one-cold.
module dec_onehot
   import dec_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter bit ACTIVE_LOW = 1'b0,
   localparam int OUT_W     = 2**SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] out
);

   always_comb begin
      out      = '0;
      out[sel] = 1'b1;
      out      = out ^ {OUT_W{ACTIVE_LOW}};
   end

endmodule

// File: rtl/dec_n_seq.sv
// Registered N-to-2^N decoder with handshake and autonomous scan mode.
// Define DEC_N_SEQ_PARITY_EN to add odd-parity checking on DIRECT input.
module dec_n_seq
   import dec_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0,
   localparam int OUT_W     = 2**SEL_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             en,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [SEL_W-1:0] in_sel,
`ifdef DEC_N_SEQ_PARITY_EN
   input  logic             in_par,
   output logic             par_err,
`endif
   output logic             in_ready,
   output logic [OUT_W-1:0] out,
   output logic             out_valid,
   output logic [SEL_W-1:0] cur_sel,
   output logic             wrap
);

   localparam int CNT_W = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{ACTIVE_LOW}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [OUT_W-1:0] dec_out;
   logic             vld_q, vld_d;
   logic             wrap_q, wrap_d;
   logic             par_q, par_d;
   logic [SEL_W:0]   sel_inc;
   logic             par_ok;
   logic             xfer;

`ifdef DEC_N_SEQ_PARITY_EN
   assign par_ok  = ^{in_sel, in_par};
   assign par_err = par_q;
`else
   assign par_ok  = 1'b1;
`endif

   assign in_ready = (state_q == ST_DIRECT);
   assign xfer     = in_valid & in_ready & par_ok;
   // Carry out of the increment marks the wrap back to code 0.
   assign sel_inc  = {1'b0, sel_q} + (SEL_W + 1)'(1);

   always_comb begin
      if (!en) begin
         state_d = ST_IDLE;
      end else if (mode == MODE_DIRECT) begin
         state_d = ST_DIRECT;
      end else begin
         state_d = ST_SCAN;
      end
   end

   always_comb begin
      sel_d  = sel_q;
      vld_d  = vld_q;
      cnt_d  = '0;
      wrap_d = 1'b0;
      par_d  = in_valid & in_ready & ~par_ok;
      unique case (state_d)
         ST_IDLE: begin
            vld_d = 1'b0;
         end
         ST_DIRECT: begin
            if (state_q != ST_DIRECT) begin
               vld_d = 1'b0;
            end else if (xfer) begin
               sel_d = in_sel;
               vld_d = 1'b1;
            end
         end
         ST_SCAN: begin
            vld_d = 1'b1;
            if (state_q != ST_SCAN) begin
               sel_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               sel_d  = sel_inc[SEL_W-1:0];
               wrap_d = sel_inc[SEL_W];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            vld_d = 1'b0;
         end
      endcase
   end

   dec_onehot #(
      .SEL_W      (SEL_W),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_onehot (
      .sel (sel_d),
      .out (dec_out)
   );

   assign out_d = vld_d ? dec_out : OUT_IDLE;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         out_q   <= OUT_IDLE;
         vld_q   <= 1'b0;
         wrap_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         wrap_q  <= wrap_d;
         par_q   <= par_d;
      end
   end

   assign out       = out_q;
   assign out_valid = vld_q;
   assign cur_sel   = sel_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_dec_n_seq.sv
// Directed bench for dec_n_seq: active-high, active-low and DWELL=1 copies.
module tb_dec_n_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       mode;
   logic       in_valid;
   logic [2:0] in_sel;

   logic       rdy_hi, vld_hi, wrap_hi;
   logic [7:0] out_hi;
   logic [2:0] sel_hi;
   logic       rdy_lo, vld_lo, wrap_lo;
   logic [7:0] out_lo;
   logic [2:0] sel_lo;
   logic       rdy_d1, vld_d1, wrap_d1;
   logic [7:0] out_d1;
   logic [2:0] sel_d1;

`ifdef DEC_N_SEQ_PARITY_EN
   logic in_par;
   logic par_man;
   logic par_val;
   logic perr_hi, perr_lo, perr_d1;
   assign in_par = par_man ? par_val : ~(^in_sel);
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dec_n_seq #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_hi (
      .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode),
      .in_valid(in_valid), .in_sel(in_sel),
`ifdef DEC_N_SEQ_PARITY_EN
      .in_par(in_par), .par_err(perr_hi),
`endif
      .in_ready(rdy_hi), .out(out_hi), .out_valid(vld_hi),
      .cur_sel(sel_hi), .wrap(wrap_hi)
   );

   dec_n_seq #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b1)) u_lo (
      .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode),
      .in_valid(in_valid), .in_sel(in_sel),
`ifdef DEC_N_SEQ_PARITY_EN
      .in_par(in_par), .par_err(perr_lo),
`endif
      .in_ready(rdy_lo), .out(out_lo), .out_valid(vld_lo),
      .cur_sel(sel_lo), .wrap(wrap_lo)
   );

   dec_n_seq #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u_d1 (
      .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode),
      .in_valid(in_valid), .in_sel(in_sel),
`ifdef DEC_N_SEQ_PARITY_EN
      .in_par(in_par), .par_err(perr_d1),
`endif
      .in_ready(rdy_d1), .out(out_d1), .out_valid(vld_d1),
      .cur_sel(sel_d1), .wrap(wrap_d1)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 1'b0;
      in_valid = 1'b0; in_sel = 3'd0;
`ifdef DEC_N_SEQ_PARITY_EN
      par_man = 1'b0; par_val = 1'b0;
`endif
      #2;
      n_cmp++; if (out_hi !== 8'h00) begin n_err++; $display("FAIL rst_out_hi got=%h exp=00", out_hi); end
      n_cmp++; if (out_lo !== 8'hFF) begin n_err++; $display("FAIL rst_out_lo got=%h exp=FF", out_lo); end
      n_cmp++; if (out_d1 !== 8'h00) begin n_err++; $display("FAIL rst_out_d1 got=%h exp=00", out_d1); end
      n_cmp++; if ({vld_hi, vld_lo, vld_d1} !== 3'b000) begin n_err++; $display("FAIL rst_valid got=%b exp=000", {vld_hi, vld_lo, vld_d1}); end
      n_cmp++; if ({rdy_hi, rdy_lo, rdy_d1} !== 3'b000) begin n_err++; $display("FAIL rst_ready got=%b exp=000", {rdy_hi, rdy_lo, rdy_d1}); end
      n_cmp++; if ({wrap_hi, wrap_lo, wrap_d1} !== 3'b000) begin n_err++; $display("FAIL rst_wrap got=%b exp=000", {wrap_hi, wrap_lo, wrap_d1}); end
      n_cmp++; if ({sel_hi, sel_lo, sel_d1} !== 9'd0) begin n_err++; $display("FAIL rst_sel got=%h exp=0", {sel_hi, sel_lo, sel_d1}); end
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_direct();
      en = 1'b1; mode = 1'b0;
      tick(1);
      n_cmp++; if (rdy_hi !== 1'b1) begin n_err++; $display("FAIL dir_entry_ready got=%b exp=1", rdy_hi); end
      n_cmp++; if (vld_hi !== 1'b0) begin n_err++; $display("FAIL dir_entry_valid got=%b exp=0", vld_hi); end
      in_valid = 1'b1; in_sel = 3'd5;
      tick(1);
      n_cmp++; if (out_hi !== 8'b0010_0000) begin n_err++; $display("FAIL dir_out_hi got=%b exp=00100000", out_hi); end
      n_cmp++; if (out_lo !== 8'b1101_1111) begin n_err++; $display("FAIL dir_out_lo got=%b exp=11011111", out_lo); end
      n_cmp++; if (sel_hi !== 3'd5) begin n_err++; $display("FAIL dir_sel got=%0d exp=5", sel_hi); end
      n_cmp++; if (vld_hi !== 1'b1) begin n_err++; $display("FAIL dir_valid got=%b exp=1", vld_hi); end
      in_valid = 1'b0; in_sel = 3'd2;
      tick(2);
      n_cmp++; if (out_hi !== 8'b0010_0000) begin n_err++; $display("FAIL dir_hold_out got=%b exp=00100000", out_hi); end
      n_cmp++; if (sel_hi !== 3'd5) begin n_err++; $display("FAIL dir_hold_sel got=%0d exp=5", sel_hi); end
      n_cmp++; if (vld_hi !== 1'b1) begin n_err++; $display("FAIL dir_hold_valid got=%b exp=1", vld_hi); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] sels [3];
      logic [7:0] exps [3];
      sels[0] = 3'd0; exps[0] = 8'b0000_0001;
      sels[1] = 3'd7; exps[1] = 8'b1000_0000;
      sels[2] = 3'd3; exps[2] = 8'b0000_1000;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_sel = sels[i];
         tick(1);
         n_cmp++; if (out_hi !== exps[i]) begin n_err++; $display("FAIL b2b_out_hi[%0d] got=%b exp=%b", i, out_hi, exps[i]); end
         n_cmp++; if (out_lo !== ~exps[i]) begin n_err++; $display("FAIL b2b_out_lo[%0d] got=%b exp=%b", i, out_lo, ~exps[i]); end
         n_cmp++; if (sel_hi !== sels[i]) begin n_err++; $display("FAIL b2b_sel[%0d] got=%0d exp=%0d", i, sel_hi, sels[i]); end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_scan();
      logic [2:0] es;
      logic [2:0] es1;
      logic       ew;
      logic       ew1;
      int         wraps_hi = 0;
      int         wraps_d1 = 0;
      in_valid = 1'b1; in_sel = 3'd6;
      mode = 1'b1;
      tick(1);
      for (int c = 0; c <= 40; c++) begin
         es  = 3'((c / 4) % 8);
         ew  = (c == 32);
         es1 = 3'(c % 8);
         ew1 = (c > 0) && (c % 8 == 0);
         if (wrap_hi === 1'b1) wraps_hi++;
         if (wrap_d1 === 1'b1) wraps_d1++;
         n_cmp++; if (sel_hi !== es) begin n_err++; $display("FAIL scan_sel c=%0d got=%0d exp=%0d", c, sel_hi, es); end
         n_cmp++; if (wrap_hi !== ew) begin n_err++; $display("FAIL scan_wrap c=%0d got=%b exp=%b", c, wrap_hi, ew); end
         n_cmp++; if (out_hi !== (8'd1 << es)) begin n_err++; $display("FAIL scan_out c=%0d got=%b exp=%b", c, out_hi, 8'd1 << es); end
         n_cmp++; if ({vld_hi, rdy_hi} !== 2'b10) begin n_err++; $display("FAIL scan_vld_rdy c=%0d got=%b exp=10", c, {vld_hi, rdy_hi}); end
         n_cmp++; if (sel_d1 !== es1) begin n_err++; $display("FAIL scan1_sel c=%0d got=%0d exp=%0d", c, sel_d1, es1); end
         n_cmp++; if (wrap_d1 !== ew1) begin n_err++; $display("FAIL scan1_wrap c=%0d got=%b exp=%b", c, wrap_d1, ew1); end
         tick(1);
      end
      n_cmp++; if (wraps_hi !== 1) begin n_err++; $display("FAIL scan_wrap_count got=%0d exp=1", wraps_hi); end
      n_cmp++; if (wraps_d1 !== 5) begin n_err++; $display("FAIL scan1_wrap_count got=%0d exp=5", wraps_d1); end
      in_valid = 1'b0;
      tick(3);
      n_cmp++; if (sel_hi !== 3'd3) begin n_err++; $display("FAIL scan_c44_sel got=%0d exp=3", sel_hi); end
   endtask

   task automatic test_mode_switch();
      mode = 1'b0;
      tick(1);
      n_cmp++; if (rdy_hi !== 1'b1) begin n_err++; $display("FAIL sw_ready got=%b exp=1", rdy_hi); end
      n_cmp++; if (vld_hi !== 1'b0) begin n_err++; $display("FAIL sw_valid got=%b exp=0", vld_hi); end
      in_valid = 1'b1; in_sel = 3'd1;
      tick(1);
      in_valid = 1'b0;
      n_cmp++; if (out_hi !== 8'b0000_0010) begin n_err++; $display("FAIL sw_out_hi got=%b exp=00000010", out_hi); end
      n_cmp++; if (out_lo !== 8'b1111_1101) begin n_err++; $display("FAIL sw_out_lo got=%b exp=11111101", out_lo); end
      n_cmp++; if (sel_hi !== 3'd1) begin n_err++; $display("FAIL sw_sel got=%0d exp=1", sel_hi); end
      mode = 1'b1;
      tick(1);
      n_cmp++; if (sel_hi !== 3'd0) begin n_err++; $display("FAIL sw_rescan_sel got=%0d exp=0", sel_hi); end
      n_cmp++; if (out_hi !== 8'b0000_0001) begin n_err++; $display("FAIL sw_rescan_out got=%b exp=00000001", out_hi); end
      n_cmp++; if ({vld_hi, wrap_hi} !== 2'b10) begin n_err++; $display("FAIL sw_rescan_vld_wrap got=%b exp=10", {vld_hi, wrap_hi}); end
   endtask

   task automatic test_disable();
      tick(5);
      n_cmp++; if (sel_hi !== 3'd1) begin n_err++; $display("FAIL dis_pre_sel got=%0d exp=1", sel_hi); end
      en = 1'b0;
      tick(1);
      n_cmp++; if (out_hi !== 8'h00) begin n_err++; $display("FAIL dis_scan_out_hi got=%h exp=00", out_hi); end
      n_cmp++; if (out_lo !== 8'hFF) begin n_err++; $display("FAIL dis_scan_out_lo got=%h exp=FF", out_lo); end
      n_cmp++; if ({vld_hi, rdy_hi} !== 2'b00) begin n_err++; $display("FAIL dis_scan_vld_rdy got=%b exp=00", {vld_hi, rdy_hi}); end
      n_cmp++; if (sel_hi !== 3'd1) begin n_err++; $display("FAIL dis_scan_sel got=%0d exp=1", sel_hi); end
      en = 1'b1; mode = 1'b0;
      tick(1);
      in_valid = 1'b1; in_sel = 3'd6;
      tick(1);
      in_valid = 1'b0; en = 1'b0;
      tick(1);
      n_cmp++; if (out_hi !== 8'h00) begin n_err++; $display("FAIL dis_dir_out got=%h exp=00", out_hi); end
      n_cmp++; if ({vld_hi, rdy_hi} !== 2'b00) begin n_err++; $display("FAIL dis_dir_vld_rdy got=%b exp=00", {vld_hi, rdy_hi}); end
      tick(3);
      n_cmp++; if (sel_hi !== 3'd6) begin n_err++; $display("FAIL dis_idle_sel got=%0d exp=6", sel_hi); end
   endtask

   task automatic test_reset_mid_scan();
      en = 1'b1; mode = 1'b1;
      tick(1);
      tick(9);
      n_cmp++; if (out_lo !== 8'b1111_1011) begin n_err++; $display("FAIL mid_pre_out_lo got=%b exp=11111011", out_lo); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (out_lo !== 8'hFF) begin n_err++; $display("FAIL mid_rst_out_lo got=%h exp=FF", out_lo); end
      n_cmp++; if (out_hi !== 8'h00) begin n_err++; $display("FAIL mid_rst_out_hi got=%h exp=00", out_hi); end
      n_cmp++; if ({vld_lo, wrap_lo, vld_d1} !== 3'b000) begin n_err++; $display("FAIL mid_rst_vld_wrap got=%b exp=000", {vld_lo, wrap_lo, vld_d1}); end
      n_cmp++; if ({sel_lo, sel_d1} !== 6'd0) begin n_err++; $display("FAIL mid_rst_sel got=%h exp=0", {sel_lo, sel_d1}); end
      en = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

`ifdef DEC_N_SEQ_PARITY_EN
   task automatic test_parity();
      en = 1'b1; mode = 1'b0;
      tick(1);
      par_man = 1'b1;
      in_valid = 1'b1; in_sel = 3'd5; par_val = 1'b1;
      tick(1);
      n_cmp++; if (out_hi !== 8'b0010_0000) begin n_err++; $display("FAIL par_good_out got=%b exp=00100000", out_hi); end
      n_cmp++; if (perr_hi !== 1'b0) begin n_err++; $display("FAIL par_good_err got=%b exp=0", perr_hi); end
      in_sel = 3'd3; par_val = 1'b0;
      tick(1);
      n_cmp++; if (perr_hi !== 1'b1) begin n_err++; $display("FAIL par_bad_err got=%b exp=1", perr_hi); end
      n_cmp++; if (out_hi !== 8'b0010_0000) begin n_err++; $display("FAIL par_bad_out got=%b exp=00100000", out_hi); end
      n_cmp++; if (sel_hi !== 3'd5) begin n_err++; $display("FAIL par_bad_sel got=%0d exp=5", sel_hi); end
      par_val = 1'b1;
      tick(1);
      n_cmp++; if (out_hi !== 8'b0000_1000) begin n_err++; $display("FAIL par_fix_out got=%b exp=00001000", out_hi); end
      n_cmp++; if ({perr_hi, perr_lo, perr_d1} !== 3'b000) begin n_err++; $display("FAIL par_fix_err got=%b exp=000", {perr_hi, perr_lo, perr_d1}); end
      in_valid = 1'b0; par_man = 1'b0;
      tick(1);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_direct();
      test_back_to_back();
      test_scan();
      test_mode_switch();
      test_disable();
      test_reset_mid_scan();
`ifdef DEC_N_SEQ_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
